// File: rtl/asip_pkg.sv
// Shared constants, op-code enum and channel operation for the pixel ASIP.
// Optional grayscale datapath is enabled by defining ASIP_GRAY_EN.
package asip_pkg;

  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] H_FP    = 10'd16;
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BP    = 10'd48;
  localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] H_SS    = H_VIS + H_FP;
  localparam logic [9:0] H_SE    = H_SS + H_SYNC;
  localparam logic [9:0] H_MAX   = H_TOTAL - 10'd1;

  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] V_FP    = 10'd10;
  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_BP    = 10'd33;
  localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] V_SS    = V_VIS + V_FP;
  localparam logic [9:0] V_SE    = V_SS + V_SYNC;
  localparam logic [9:0] V_MAX   = V_TOTAL - 10'd1;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_DBL  = 2'd1,
    OP_HALF = 2'd2,
    OP_INV  = 2'd3
  } op_t;

  typedef struct packed {
    logic halt;
    op_t  r_op;
    op_t  g_op;
    op_t  b_op;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{halt: 1'b1, r_op: OP_PASS, g_op: OP_PASS, b_op: OP_PASS};

  function automatic logic [7:0] chan_op(input op_t op, input logic [7:0] c);
    case (op)
      OP_DBL:  return c[7] ? 8'hFF : {c[6:0], 1'b0};
      OP_HALF: return {1'b0, c[7:1]};
      OP_INV:  return 8'hFF - c;
      default: return c;
    endcase
  endfunction

endpackage

// File: rtl/asip_vga_timing.sv
// 640x480@60 raster generator: divides clk by two and produces pixel tick,
// scan counters, visible flag and raw (unregistered) active-low syncs.
module asip_vga_timing
  import asip_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic       vga_clk,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       visible,
  output logic       hs,
  output logic       vs
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vga_clk <= 1'b0;
    else      vga_clk <= ~vga_clk;
  end

  // The tick coincides with the clk edge on which vga_clk rises.
  assign pix_en = ~vga_clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (hcount == H_MAX) begin
        hcount <= '0;
        vcount <= (vcount == V_MAX) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  assign visible = (hcount < H_VIS) && (vcount < V_VIS);
  assign hs      = ~((hcount >= H_SS) && (hcount < H_SE));
  assign vs      = ~((vcount >= V_SS) && (vcount < V_SE));

endmodule

// File: rtl/asip_core.sv
// Pixel ASIP top: switch synchronizers, frame-aligned config latch, per-channel
// op datapath and VGA output registers. Define ASIP_GRAY_EN for grayscale mode.
module asip_core
  import asip_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  red_switches,
  input  logic [1:0]  green_switches,
  input  logic [1:0]  blue_switches,
  input  logic        gtype_switch,
  input  logic        switchStart,
  output logic [23:0] rgb,
  output logic        v_sync,
  output logic        h_sync,
  output logic        vga_clk
);

  logic       pix_en;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       visible;
  logic       hs_raw;
  logic       vs_raw;

  asip_vga_timing u_timing (
    .clk     (clk),
    .rst     (rst),
    .vga_clk (vga_clk),
    .pix_en  (pix_en),
    .hcount  (hcount),
    .vcount  (vcount),
    .visible (visible),
    .hs      (hs_raw),
    .vs      (vs_raw)
  );

  logic [6:0] sw_s1;
  logic [6:0] sw_s2;
  cfg_t       cfg;
  logic       frame_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= {switchStart, red_switches, green_switches, blue_switches};
      sw_s2 <= sw_s1;
    end
  end

  // Latch on the last tick of a frame so the new config governs pixel (0,0) onward.
  assign frame_last = pix_en && (hcount == H_MAX) && (vcount == V_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            cfg <= CFG_RESET;
    else if (frame_last) cfg <= '{halt: sw_s2[6], r_op: op_t'(sw_s2[5:4]),
                                  g_op: op_t'(sw_s2[3:2]), b_op: op_t'(sw_s2[1:0])};
  end

`ifdef ASIP_GRAY_EN
  logic       gt_s1;
  logic       gt_s2;
  logic       gray_mode;
  logic [9:0] gray_sum;
  logic [7:0] gray;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gt_s1     <= 1'b0;
      gt_s2     <= 1'b0;
      gray_mode <= 1'b0;
    end else begin
      gt_s1 <= gtype_switch;
      gt_s2 <= gt_s1;
      if (frame_last) gray_mode <= gt_s2;
    end
  end
`else
  logic unused_gtype;
  assign unused_gtype = gtype_switch;
`endif

  logic [7:0]  base_r;
  logic [7:0]  base_g;
  logic [7:0]  base_b;
  logic [7:0]  r_c;
  logic [7:0]  g_c;
  logic [7:0]  b_c;
  logic [23:0] pix_next;

  assign base_r = hcount[7:0];
  assign base_g = vcount[7:0];
  assign base_b = hcount[7:0] ^ vcount[7:0];

`ifdef ASIP_GRAY_EN
  assign gray_sum = {2'b00, base_r} + {1'b0, base_g, 1'b0} + {2'b00, base_b};
  assign gray     = gray_sum[9:2];
`endif

  always_comb begin
    r_c = chan_op(cfg.r_op, base_r);
    g_c = chan_op(cfg.g_op, base_g);
    b_c = chan_op(cfg.b_op, base_b);
`ifdef ASIP_GRAY_EN
    if (gray_mode) begin
      r_c = chan_op(cfg.r_op, gray);
      g_c = r_c;
      b_c = r_c;
    end
`endif
    pix_next = (visible && !cfg.halt) ? {r_c, g_c, b_c} : 24'h0;
  end

  // Output stage: colour and syncs sampled from the same counter values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb    <= '0;
      h_sync <= 1'b1;
      v_sync <= 1'b1;
    end else if (pix_en) begin
      rgb    <= pix_next;
      h_sync <= hs_raw;
      v_sync <= vs_raw;
    end
  end

endmodule

// File: tb/tb_asip_core.sv
// Directed bench for asip_core: reset, sync timing, colour ops, grayscale,
// halt at frame boundary and asynchronous mid-line reset.
module tb_asip_core;

  logic        clk;
  logic        rst;
  logic [1:0]  red_switches;
  logic [1:0]  green_switches;
  logic [1:0]  blue_switches;
  logic        gtype_switch;
  logic        switchStart;
  logic [23:0] rgb;
  logic        v_sync;
  logic        h_sync;
  logic        vga_clk;

  asip_core dut (
    .clk            (clk),
    .rst            (rst),
    .red_switches   (red_switches),
    .green_switches (green_switches),
    .blue_switches  (blue_switches),
    .gtype_switch   (gtype_switch),
    .switchStart    (switchStart),
    .rgb            (rgb),
    .v_sync         (v_sync),
    .h_sync         (h_sync),
    .vga_clk        (vga_clk)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int     tests;
  int     fails;
  longint cyc;
  longint first_h_fall;
  longint last_h_fall;
  longint last_v_fall;
  longint v_len;
  int     h_falls;
  int     v_falls;
  int     h_wid_bad;
  int     h_per_bad;
  int     rgb_nz;
  int     vck_bad;
  logic   prev_h;
  logic   prev_v;

  task automatic clear_stats();
    first_h_fall = -1;
    last_h_fall  = -1;
    last_v_fall  = -1;
    v_len        = -1;
    h_falls      = 0;
    v_falls      = 0;
    h_wid_bad    = 0;
    h_per_bad    = 0;
    rgb_nz       = 0;
    vck_bad      = 0;
  endtask

  // Advance one clk edge (counted from reset release) and record sync/rgb activity.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (vga_clk !== cyc[0]) vck_bad++;
    if (rgb !== 24'h0) rgb_nz++;
    if (prev_h === 1'b1 && h_sync === 1'b0) begin
      h_falls++;
      if (first_h_fall < 0) first_h_fall = cyc;
      if (last_h_fall >= 0 && cyc - last_h_fall != 1600) h_per_bad++;
      last_h_fall = cyc;
    end
    if (prev_h === 1'b0 && h_sync === 1'b1) begin
      if (last_h_fall >= 0 && cyc - last_h_fall != 192) h_wid_bad++;
    end
    if (prev_v === 1'b1 && v_sync === 1'b0) begin
      v_falls++;
      last_v_fall = cyc;
    end
    if (prev_v === 1'b0 && v_sync === 1'b1 && last_v_fall >= 0) v_len = cyc - last_v_fall;
    prev_h = h_sync;
    prev_v = v_sync;
  endtask

  task automatic run_to(input longint e);
    while (cyc < e) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    red_switches = 2'd0; green_switches = 2'd0; blue_switches = 2'd0;
    gtype_switch = 1'b0; switchStart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (rgb !== 24'h0) begin fails++; $display("FAIL reset_rgb: got %h expected %h", rgb, 24'h0); end
    tests++; if (h_sync !== 1'b1) begin fails++; $display("FAIL reset_hsync: got %b expected 1", h_sync); end
    tests++; if (v_sync !== 1'b1) begin fails++; $display("FAIL reset_vsync: got %b expected 1", v_sync); end
    tests++; if (vga_clk !== 1'b0) begin fails++; $display("FAIL reset_vgaclk: got %b expected 0", vga_clk); end
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    prev_h = 1'b1;
    prev_v = 1'b1;
    clear_stats();
  endtask

  task automatic test_first_frame();
    run_to(840000);
    tests++; if (rgb_nz !== 0) begin fails++; $display("FAIL frame1_black: nonzero samples %0d expected 0", rgb_nz); end
    tests++; if (vck_bad !== 0) begin fails++; $display("FAIL vga_clk_toggle: bad samples %0d expected 0", vck_bad); end
    tests++; if (first_h_fall !== 64'sd1313) begin fails++; $display("FAIL hsync_first_fall: got %0d expected 1313", first_h_fall); end
    tests++; if (h_falls !== 525) begin fails++; $display("FAIL hsync_count: got %0d expected 525", h_falls); end
    tests++; if (h_wid_bad !== 0) begin fails++; $display("FAIL hsync_width: bad pulses %0d expected 0", h_wid_bad); end
    tests++; if (h_per_bad !== 0) begin fails++; $display("FAIL hsync_period: bad periods %0d expected 0", h_per_bad); end
    tests++; if (v_falls !== 1) begin fails++; $display("FAIL vsync_count: got %0d expected 1", v_falls); end
    tests++; if (last_v_fall !== 64'sd784001) begin fails++; $display("FAIL vsync_fall: got %0d expected 784001", last_v_fall); end
    tests++; if (v_len !== 64'sd3200) begin fails++; $display("FAIL vsync_width: got %0d expected 3200", v_len); end
  endtask

  task automatic test_colour();
    run_to(872021);  // frame 2, pixel (10,20)
    tests++; if (rgb !== 24'h0A141E) begin fails++; $display("FAIL colour_pass: got %h expected %h", rgb, 24'h0A141E); end
    red_switches = 2'd1; green_switches = 2'd2; blue_switches = 2'd3;
  endtask

  task automatic test_ops();
    run_to(1712401);  // frame 3, pixel (200,20)
    tests++; if (rgb !== 24'hFF0A23) begin fails++; $display("FAIL ops_200_20: got %h expected %h", rgb, 24'hFF0A23); end
    gtype_switch = 1'b1;
    red_switches = 2'd0; green_switches = 2'd0; blue_switches = 2'd0;
    run_to(1840401);  // frame 3, pixel (200,100): mid-frame switch change must not apply yet
    tests++; if (rgb !== 24'hFF3253) begin fails++; $display("FAIL ops_no_tear: got %h expected %h", rgb, 24'hFF3253); end
  endtask

  task automatic test_gray();
    logic [23:0] exp_a;
    logic [23:0] exp_b;
`ifdef ASIP_GRAY_EN
    exp_a = 24'h141414;
    exp_b = 24'h212121;
`else
    exp_a = 24'h0A141E;
    exp_b = 24'h2C2C00;
`endif
    run_to(2552021);  // frame 4, pixel (10,20)
    tests++; if (rgb !== exp_a) begin fails++; $display("FAIL gray_10_20: got %h expected %h", rgb, exp_a); end
    switchStart = 1'b1;
    run_to(3000601);  // frame 4, pixel (300,300): halt request still pending
    tests++; if (rgb !== exp_b) begin fails++; $display("FAIL halt_pending: got %h expected %h", rgb, exp_b); end
  endtask

  task automatic test_halt();
    run_to(3360000);
    clear_stats();
    run_to(4145401);  // frame 5, line 490, hcount 700
    tests++; if (rgb_nz !== 0) begin fails++; $display("FAIL halt_black: nonzero samples %0d expected 0", rgb_nz); end
    tests++; if (h_falls !== 491) begin fails++; $display("FAIL halt_hsync: got %0d expected 491", h_falls); end
    tests++; if (h_wid_bad !== 0 || h_per_bad !== 0) begin fails++; $display("FAIL halt_hsync_shape: width bad %0d period bad %0d expected 0", h_wid_bad, h_per_bad); end
    tests++; if (last_v_fall !== 64'sd4144001) begin fails++; $display("FAIL halt_vsync: got %0d expected 4144001", last_v_fall); end
  endtask

  task automatic test_async_reset();
    tests++; if (h_sync !== 1'b0 || v_sync !== 1'b0) begin fails++; $display("FAIL pre_reset_syncs: got h=%b v=%b expected 0 0", h_sync, v_sync); end
    rst = 1'b0;
    #1;
    tests++; if (h_sync !== 1'b1) begin fails++; $display("FAIL async_hsync: got %b expected 1", h_sync); end
    tests++; if (v_sync !== 1'b1) begin fails++; $display("FAIL async_vsync: got %b expected 1", v_sync); end
    tests++; if (vga_clk !== 1'b0) begin fails++; $display("FAIL async_vgaclk: got %b expected 0", vga_clk); end
    tests++; if (rgb !== 24'h0) begin fails++; $display("FAIL async_rgb: got %h expected %h", rgb, 24'h0); end
    @(negedge clk);
    switchStart = 1'b0;
    rst = 1'b1;
    cyc = 0;
    prev_h = 1'b1;
    prev_v = 1'b1;
    clear_stats();
    run_to(1320);
    tests++; if (first_h_fall !== 64'sd1313) begin fails++; $display("FAIL restart_hsync: got %0d expected 1313", first_h_fall); end
    tests++; if (rgb_nz !== 0) begin fails++; $display("FAIL restart_black: nonzero samples %0d expected 0", rgb_nz); end
    tests++; if (vck_bad !== 0) begin fails++; $display("FAIL restart_vgaclk: bad samples %0d expected 0", vck_bad); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    prev_h = 1'b1;
    prev_v = 1'b1;
    clear_stats();
    test_reset();
    test_first_frame();
    test_colour();
    test_ops();
    test_gray();
    test_halt();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/asip_core.md
# asip_core

Pixel-processing ASIP top level (module asip_core) with an integrated VGA 640x480@60 output stage. It generates a procedural base image from the scan position and applies a switch-selected per-channel operation, with an optional grayscale reduction, to every pixel. The processed pixels stream straight to the board VGA DAC pins. It is the FPGA top of the image-processing project, fed by board slide switches.

## Interface
- No parameters; timing constants come from the package.
- clk  in  1  50 MHz system clock.
- rst  in  1  reset; one clock, asynchronous assert, active-low.
- red_switches  in  2  red channel op code.
- green_switches  in  2  green channel op code.
- blue_switches  in  2  blue channel op code.
- gtype_switch  in  1  0 = colour mode, 1 = grayscale mode.
- switchStart  in  1  1 = halt (black output), 0 = run.
- rgb  out  24  {R[23:16], G[15:8], B[7:0]}.
- v_sync  out  1  vertical sync, active-low.
- h_sync  out  1  horizontal sync, active-low.
- vga_clk  out  1  25 MHz pixel clock, clk/2.

## Operation
- All switch inputs pass through 2-flop synchronizers. Synchronized values are latched into a config register only on the pixel tick where hcount=0 and vcount=0 (frame start), so the image never tears.
- Config register resets to: halt=1, all codes=0, gtype=0. The first frame after reset is therefore black.
- Base pixel at visible (x,y): R=x[7:0], G=y[7:0], B=x[7:0]^y[7:0].
- Op code per channel c (8-bit):
  - 0: pass.
  - 1: c<<1, saturated to 255.
  - 2: c>>1.
  - 3: 255-c.
- Grayscale mode: gray=(R+2G+B)>>2, computed with a 10-bit sum. The red code is applied to gray, and the result drives all three channels. Green and blue codes are ignored.
- rgb=0 outside the visible area, and whenever halt=1.

## Timing
- vga_clk toggles every clk. Pixel tick pix_en is high on the clk where vga_clk rises.
- Counters advance only on pix_en.
  - hcount 0..799: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
  - vcount 0..524: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
  - vcount increments when hcount wraps 799→0. Both counters wrap to 0 at 799/524.
- h_sync, v_sync and rgb are registered together on pix_en from the same counter values, so they are mutually aligned.
- Line = 1600 clk. Frame = 840000 clk.
- Reset values: rgb=0, h_sync=1, v_sync=1, vga_clk=0, counters=0, synchronizers=0.
- Reset mid-frame restarts at hcount=vcount=0 with halt=1.
- Switch changes mid-frame take effect at the next frame start. The minimum switch-to-pixel delay is 2 clk of synchronizer latency plus the wait for frame start.

## Configuration
- ASIP_GRAY_EN defined: grayscale mode is available as above.
- ASIP_GRAY_EN undefined: gray logic is removed, gtype_switch is ignored, and behaviour is always colour mode.

## Structure
- Package asip_pkg holds:
  - H/V visible, porch, sync and total constants.
  - An op-code enum: OP_PASS, OP_DBL, OP_HALF, OP_INV.
  - The channel-op function.
- Sub-module asip_vga_timing produces pix_en, hcount, vcount, visible, and raw hs/vs.
- Top asip_core holds the synchronizers, config latch, pixel datapath and output registers.

## Test plan
- Reset then release with switchStart=0: first frame rgb=0 throughout. h_sync low exactly 192 clk every 1600 clk. v_sync low 3200 clk every 840000 clk.
- Colour mode, all codes 0, frame 2: pixel (10,20) gives rgb=0x0A141E.
- red=1, green=2, blue=3: pixel (200,20) gives R=255 (saturated), G=10, B=255-(200^20)=0x23.
- ASIP_GRAY_EN defined, gtype=1, red=0: pixel (10,20) gives rgb=0x141414. With the macro undefined, the same stimulus gives 0x0A141E.
- switchStart 0→1 mid-frame: current frame completes unchanged, next frame is all-zero rgb, and syncs continue.
- Assert rst mid-line: all outputs take their reset values immediately (asynchronous). After release, h_sync first falls 656 pixel ticks later.
